// File: rtl/packet_buffer_bank.sv
// Four-queue priority packet buffer: per-queue circular FIFOs with a one-hot pop port.
// Optional DROP_COUNTER_EN macro enables the saturating discarded-packet counter.
module packet_buffer_bank #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_prio,
  input  logic [3:0]        read_from,
  output logic [2:0]        current_data_count0,
  output logic [2:0]        current_data_count1,
  output logic [2:0]        current_data_count2,
  output logic [2:0]        current_data_count3,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_queue,
  output logic              drop_pulse,
  output logic              read_err,
  output logic [7:0]        drop_count
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [2:0] LAST_C  = 3'(DEPTH - 1);

  function automatic logic [2:0] bump(input logic [2:0] ptr);
    return (ptr == LAST_C) ? 3'd0 : ptr + 3'd1;
  endfunction

  logic [3:0][2:0]        count_vec;
  logic [3:0][DATA_W-1:0] head_vec;
  logic [3:0]             pop_hit;
  logic [3:0]             accept;
  logic                   multi_sel;
  logic                   pop_req;
  logic                   pop_valid;
  logic [1:0]             pop_sel;
  logic                   drop;

  always_comb begin
    pop_sel   = 2'd0;
    multi_sel = (read_from & (read_from - 4'd1)) != 4'd0;
    pop_req   = (read_from != 4'd0) && !multi_sel;
    for (int i = 0; i < 4; i++) begin
      if (read_from[i]) pop_sel = 2'(i);
    end
  end

  // An empty queue never pops, even when it is being written on the same edge.
  assign pop_valid = pop_req && (count_vec[pop_sel] != 3'd0);
  assign drop      = in_valid && (count_vec[in_prio] == DEPTH_C) && !pop_hit[in_prio];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_queue
      logic [2:0]        wptr_reg;
      logic [2:0]        rptr_reg;
      logic [2:0]        count_reg;
      logic [DATA_W-1:0] mem [DEPTH];
      logic              wr_hit;

      assign wr_hit      = in_valid && (in_prio == 2'(gi));
      assign pop_hit[gi] = pop_valid && (pop_sel == 2'(gi));
      // A full queue still accepts a write when its head leaves on the same edge.
      assign accept[gi]  = wr_hit && ((count_reg != DEPTH_C) || pop_hit[gi]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wptr_reg  <= 3'd0;
          rptr_reg  <= 3'd0;
          count_reg <= 3'd0;
        end else begin
          if (accept[gi]) wptr_reg <= bump(wptr_reg);
          if (pop_hit[gi]) rptr_reg <= bump(rptr_reg);
          count_reg <= count_reg + 3'(accept[gi]) - 3'(pop_hit[gi]);
        end
      end

      always_ff @(posedge clk) begin
        if (accept[gi]) mem[wptr_reg] <= in_data;
      end

      assign count_vec[gi] = count_reg;
      assign head_vec[gi]  = mem[rptr_reg];
    end
  endgenerate

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [1:0]        out_queue_reg;
  logic              drop_pulse_reg;
  logic              read_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_queue_reg  <= 2'd0;
      drop_pulse_reg <= 1'b0;
      read_err_reg   <= 1'b0;
    end else begin
      out_valid_reg  <= pop_valid;
      drop_pulse_reg <= drop;
      read_err_reg   <= multi_sel;
      if (pop_valid) begin
        out_data_reg  <= head_vec[pop_sel];
        out_queue_reg <= pop_sel;
      end
    end
  end

`ifdef DROP_COUNTER_EN
  logic [7:0] drop_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_reg <= 8'd0;
    end else if (drop && (drop_count_reg != 8'hFF)) begin
      drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  assign drop_count = drop_count_reg;
`else
  assign drop_count = 8'd0;
`endif

  assign current_data_count0 = count_vec[0];
  assign current_data_count1 = count_vec[1];
  assign current_data_count2 = count_vec[2];
  assign current_data_count3 = count_vec[3];
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_queue  = out_queue_reg;
  assign drop_pulse = drop_pulse_reg;
  assign read_err   = read_err_reg;

endmodule

// File: tb/tb_packet_buffer_bank.sv
// Directed, table-driven bench for packet_buffer_bank plus hand-written wrap and reset sequences.
module tb_packet_buffer_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic [1:0] in_prio = 2'd0;
  logic [3:0] read_from = 4'd0;
  logic [2:0] current_data_count0, current_data_count1, current_data_count2, current_data_count3;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_queue;
  logic       drop_pulse;
  logic       read_err;
  logic [7:0] drop_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  packet_buffer_bank #(.DATA_W(4), .DEPTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_prio(in_prio),
    .read_from(read_from),
    .current_data_count0(current_data_count0), .current_data_count1(current_data_count1),
    .current_data_count2(current_data_count2), .current_data_count3(current_data_count3),
    .out_valid(out_valid), .out_data(out_data), .out_queue(out_queue),
    .drop_pulse(drop_pulse), .read_err(read_err), .drop_count(drop_count)
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [1:0] p;
    logic [3:0] rf;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] eq;
    logic       edrop;
    logic       eerr;
    logic [2:0] c0, c1, c2, c3;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int v, d, p, rf, ev, ed, eq, edrop, eerr, c0, c1, c2, c3);
    vec_t t;
    t.v = 1'(v); t.d = 4'(d); t.p = 2'(p); t.rf = 4'(rf);
    t.ev = 1'(ev); t.ed = 4'(ed); t.eq = 2'(eq); t.edrop = 1'(edrop); t.eerr = 1'(eerr);
    t.c0 = 3'(c0); t.c1 = 3'(c1); t.c2 = 3'(c2); t.c3 = 3'(c3);
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] p, input logic [3:0] rf);
    in_valid = v; in_data = d; in_prio = p; read_from = rf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int c0, c1, c2, c3);
    check({tag, " count0"}, 32'(current_data_count0), 32'(c0));
    check({tag, " count1"}, 32'(current_data_count1), 32'(c1));
    check({tag, " count2"}, 32'(current_data_count2), 32'(c2));
    check({tag, " count3"}, 32'(current_data_count3), 32'(c3));
  endtask

  int exp_drops;

  initial begin
`ifdef DROP_COUNTER_EN
    exp_drops = 1;
`else
    exp_drops = 0;
`endif
    // Queue 2 fill then overflow
    for (int k = 1; k <= 6; k++) add(1, k, 2, 0, 0, 0, 0, 0, 0, 0, 0, k, 0);
    add(1, 7, 2, 0, 0, 0, 0, 1, 0, 0, 0, 6, 0);
    // Queue 0 fill and drain with held read_from
    add(1, 'hA, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0);
    add(1, 'hB, 0, 0, 0, 0, 0, 0, 0, 2, 0, 6, 0);
    add(1, 'hC, 0, 0, 0, 0, 0, 0, 0, 3, 0, 6, 0);
    add(0, 0, 0, 1, 1, 'hA, 0, 0, 0, 2, 0, 6, 0);
    add(0, 0, 0, 1, 1, 'hB, 0, 0, 0, 1, 0, 6, 0);
    add(0, 0, 0, 1, 1, 'hC, 0, 0, 0, 0, 0, 6, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    // Empty queue 1: write plus pop request, no bypass
    add(1, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    add(0, 0, 0, 2, 1, 5, 1, 0, 0, 0, 0, 6, 0);
    // Multi-bit read_from
    add(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    add(0, 0, 0, 6, 0, 0, 0, 0, 1, 0, 1, 6, 0);
    // Queue 3 full with same-edge write and pop
    for (int k = 0; k <= 5; k++) add(1, k, 3, 0, 0, 0, 0, 0, 0, 0, 1, 6, k + 1);
    add(1, 'hF, 3, 8, 1, 0, 3, 0, 0, 0, 1, 6, 6);
    // Queue 2 drain with a mid-stream write+pop; overflowed 0x7 must not appear
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 4, 1, k, 2, 0, 0, 0, 1, 6 - k, 6);
    add(1, 8, 2, 4, 1, 4, 2, 0, 0, 0, 1, 3, 6);
    add(0, 0, 0, 4, 1, 5, 2, 0, 0, 0, 1, 2, 6);
    add(0, 0, 0, 4, 1, 6, 2, 0, 0, 0, 1, 1, 6);
    add(0, 0, 0, 4, 1, 8, 2, 0, 0, 0, 1, 0, 6);
    add(0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 6);
    // Queue 3 drain: new tail 0xF comes last
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 8, 1, k, 3, 0, 0, 0, 1, 0, 6 - k);
    add(0, 0, 0, 8, 1, 'hF, 3, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 2, 1, 9, 1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset with no clock edge involved
    #2 rst_n = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset drop_pulse", 32'(drop_pulse), 32'd0);
    check("reset read_err", 32'(read_err), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_queue", 32'(out_queue), 32'd0);
    check("reset drop_count", 32'(drop_count), 32'd0);
    check_counts("reset", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].rf);
      step();
      check({tag, " out_valid"}, 32'(out_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        check({tag, " out_data"}, 32'(out_data), 32'(vecs[i].ed));
        check({tag, " out_queue"}, 32'(out_queue), 32'(vecs[i].eq));
      end
      check({tag, " drop_pulse"}, 32'(drop_pulse), 32'(vecs[i].edrop));
      check({tag, " read_err"}, 32'(read_err), 32'(vecs[i].eerr));
      check_counts(tag, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3);
      $display("vec%0d v=%0d d=%0h p=%0d rf=%b -> ov=%0d od=%0h oq=%0d drop=%0d err=%0d", i,
               vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].rf, out_valid, out_data, out_queue,
               drop_pulse, read_err);
    end

    // Output hold while idle
    drive(0, 0, 0, 0);
    step();
    check("hold out_valid", 32'(out_valid), 32'd0);
    check("hold out_data", 32'(out_data), 32'h9);
    check("hold out_queue", 32'(out_queue), 32'd1);
    check("drop_count total", 32'(drop_count), 32'(exp_drops));

    // Pointer wrap on queue 0: fill, then ten full-queue write+pop cycles
    for (int k = 0; k < 6; k++) begin
      drive(1, 4'(k), 0, 0);
      step();
    end
    check("wrap fill count0", 32'(current_data_count0), 32'd6);
    for (int k = 0; k < 10; k++) begin
      drive(1, 4'(k + 6), 0, 1);
      step();
      check($sformatf("wrap%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("wrap%0d out_data", k), 32'(out_data), 32'(k));
      check($sformatf("wrap%0d count0", k), 32'(current_data_count0), 32'd6);
      check($sformatf("wrap%0d drop", k), 32'(drop_pulse), 32'd0);
      $display("wrap%0d pop -> ov=%0d od=%0h c0=%0d", k, out_valid, out_data, current_data_count0);
    end
    drive(0, 0, 0, 1);
    step();
    check("wrap tail0 out_data", 32'(out_data), 32'hA);
    step();
    check("wrap tail1 out_data", 32'(out_data), 32'hB);
    check("wrap tail1 count0", 32'(current_data_count0), 32'd4);

    // Reset mid-pop: takes effect before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset out_data", 32'(out_data), 32'd0);
    check_counts("midreset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("midreset held count0", 32'(current_data_count0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3, 0, 1);
    step();
    check("post-reset count0", 32'(current_data_count0), 32'd1);
    check("post-reset out_valid", 32'(out_valid), 32'd0);
    drive(0, 0, 0, 1);
    step();
    check("post-reset pop valid", 32'(out_valid), 32'd1);
    check("post-reset pop data", 32'(out_data), 32'h3);
    check("post-reset pop count0", 32'(current_data_count0), 32'd0);
    $display("post-reset pop -> ov=%0d od=%0h", out_valid, out_data);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_buffer_bank.md
PACKET_BUFFER_BANK -- requirements
Module: packet_buffer_bank

Interface
REQ-001 Parameter: DATA_W, default 4, packet payload width in bits.
REQ-002 Parameter: DEPTH, default 6, slots per queue; legal range 2..7 so an occupancy fits 3 bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a packet is offered this cycle.
REQ-006 in_data  input  DATA_W  packet payload.
REQ-007 in_prio  input  2  target queue index, 0..3; queue 3 is highest priority.
REQ-008 read_from  input  4  one-hot pop request from the QoS scheduler; bit i selects queue i.
REQ-009 current_data_count0..3  output  3 each  registered occupancy of queues 0..3.
REQ-010 out_valid  output  1  one-cycle pulse; out_data and out_queue are valid.
REQ-011 out_data  output  DATA_W  popped payload.
REQ-012 out_queue  output  2  index of the queue popped.
REQ-013 drop_pulse  output  1  one-cycle pulse; the offered packet was discarded.
REQ-014 read_err  output  1  one-cycle pulse; read_from had more than one bit set.
REQ-015 drop_count  output  8  saturating count of discarded packets (see Configuration).

Function
REQ-016 The block SHALL hold four independent circular FIFOs of DEPTH x DATA_W, each with a write pointer, a read pointer and a 3-bit count.
REQ-017 Write: in_valid=1 and count[in_prio]<DEPTH SHALL store in_data at wptr[in_prio], advance that pointer and increment that count at the same edge.
REQ-018 Full: in_valid=1 and count[in_prio]==DEPTH with no same-edge pop of that queue SHALL discard the packet, leave state unchanged and assert drop_pulse on the next cycle.
REQ-019 Pop: read_from one-hot with bit i set and count[i]>0 SHALL pop the head of queue i, advance rptr[i] and decrement count[i].
REQ-020 Pop latency SHALL be one cycle: out_valid=1, out_data=head, out_queue=i in the cycle after the sampling edge.
REQ-021 read_from held across cycles SHALL pop one entry per cycle until the queue is empty.
REQ-022 read_from==0, or selecting an empty queue, SHALL produce no pop and out_valid=0.
REQ-023 read_from with two or more bits set SHALL produce no pop and assert read_err on the next cycle.
REQ-024 Write and pop of the same non-full, non-empty queue on one edge SHALL both complete, leaving the count unchanged.
REQ-025 Write to a full queue on the same edge as its pop SHALL be accepted with no drop, and the count SHALL stay DEPTH.
REQ-026 Write to an empty queue on the same edge as a pop request for it SHALL be accepted; the pop is ignored (no bypass) and the count becomes 1.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 Counts SHALL never exceed DEPTH or go below 0.
REQ-029 out_data and out_queue SHALL hold their last values while out_valid=0.
REQ-030 current_data_countN SHALL reflect the post-edge occupancy, i.e. with zero added latency from the count register.

Reset
REQ-031 rst_n=0 SHALL immediately clear all pointers, all counts, out_valid, out_data, out_queue, drop_pulse, read_err and drop_count to 0, regardless of clk.
REQ-032 FIFO storage contents SHALL NOT be reset; storage is never observable while its count is 0.
REQ-033 Reset asserted during a write or pop SHALL abort it; the first operation after deassertion is accepted on the first rising edge with rst_n=1.

Configuration
REQ-034 Macro DROP_COUNTER_EN defined: drop_count SHALL increment by 1 on every discarded packet, saturating at 255.
REQ-035 Macro DROP_COUNTER_EN undefined: drop_count SHALL be tied to 0, no counter logic SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-036 Write 6 packets 0x1..0x6 to queue 2, then a 7th (0x7) -> count2 goes 1..6; 7th gives drop_pulse=1, count2 stays 6, drop_count=1 (macro on) or 0 (macro off).
REQ-037 Queue 0 holds {0xA,0xB,0xC}; read_from=4'b0001 held 4 cycles -> out_data A, B, C on consecutive cycles with out_queue=0, then out_valid=0; count0 reaches 0.
REQ-038 Queue 3 full (6), in_prio=3 and read_from=4'b1000 on the same edge -> no drop, count3 stays 6, head popped, new packet becomes the tail.
REQ-039 Queue 1 empty, write 0x5 and read_from=4'b0010 on the same edge -> out_valid=0, count1=1; next cycle out_data=0x5.
REQ-040 read_from=4'b0110 with queues 1 and 2 non-empty -> read_err=1, out_valid=0, counts unchanged.
REQ-041 Fill queue 0 and pop 10 times interleaved to wrap the pointers; assert rst_n=0 mid-pop -> FIFO order preserved across wrap; on reset all counts are 0 and out_valid=0 immediately.
